fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_if.sv | 29 ++
 rtl/fetch_ctrl.sv | 109 ++++++++++
 tb/tb_fetch_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bundle: instruction bus request/response, redirect/predict inputs, decode buffer.
// Latency: none, wires only.
// Backpressure: decode stalls the buffer through dec_ready; the bus completes through iresp_data_ok.
interface fetch_ctrl_if;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] pred_pc;
    logic        dec_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic [63:0] inst_pcplus4;

    // Fetch controller side
    modport master (
        output ireq_valid, ireq_addr, inst_valid, inst, inst_pc, inst_pcplus4,
        input  iresp_data_ok, iresp_data, redirect_valid, redirect_pc, pred_pc, dec_ready
    );

    // Bus / execute / decode side
    modport slave (
        input  ireq_valid, ireq_addr, inst_valid, inst, inst_pc, inst_pcplus4,
        output iresp_data_ok, iresp_data, redirect_valid, redirect_pc, pred_pc, dec_ready
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding request, one-entry output buffer, redirect draining.
// Latency: instruction visible 1 cycle after iresp_data_ok; next request 1 cycle after decode accepts.
// Backpressure: no new request while the buffer is held for decode; stale responses drained in DROP.
module fetch_ctrl #(
    parameter logic [63:0] PCINIT = 64'h0000_0000_8000_0000
) (
    input logic          clk,
    input logic          reset,
    fetch_ctrl_if.master fbus
);

    typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

    state_t      state_q, state_nxt;
    logic [63:0] pc_q, pc_nxt;
    logic [63:0] req_addr_q, req_addr_nxt;
    logic        inst_valid_q, inst_valid_nxt;
    logic [31:0] inst_q, inst_nxt;
    logic [63:0] inst_pc_q, inst_pc_nxt;
    logic [63:0] inst_pcplus4_q, inst_pcplus4_nxt;

    // Request is live in FETCH and DROP; the address only moves when a response completes
    assign fbus.ireq_valid   = (state_q != HOLD);
    assign fbus.ireq_addr    = req_addr_q;
    assign fbus.inst_valid   = inst_valid_q;
    assign fbus.inst         = inst_q;
    assign fbus.inst_pc      = inst_pc_q;
    assign fbus.inst_pcplus4 = inst_pcplus4_q;

    // State and datapath registers, reset has priority over everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= FETCH;
            pc_q           <= PCINIT;
            req_addr_q     <= PCINIT;
            inst_valid_q   <= 1'b0;
            inst_q         <= 32'd0;
            inst_pc_q      <= 64'd0;
            inst_pcplus4_q <= 64'd0;
        end else begin
            state_q        <= state_nxt;
            pc_q           <= pc_nxt;
            req_addr_q     <= req_addr_nxt;
            inst_valid_q   <= inst_valid_nxt;
            inst_q         <= inst_nxt;
            inst_pc_q      <= inst_pc_nxt;
            inst_pcplus4_q <= inst_pcplus4_nxt;
        end
    end

    // Next-state and datapath selection
    always_comb begin
        state_nxt        = state_q;
        pc_nxt           = pc_q;
        req_addr_nxt     = req_addr_q;
        inst_valid_nxt   = inst_valid_q;
        inst_nxt         = inst_q;
        inst_pc_nxt      = inst_pc_q;
        inst_pcplus4_nxt = inst_pcplus4_q;
        case (state_q)
            FETCH: begin
                if (fbus.redirect_valid) begin
                    pc_nxt = fbus.redirect_pc;
                    if (fbus.iresp_data_ok) begin
                        // response belongs to the wrong path: drop it and refetch at once
                        req_addr_nxt = fbus.redirect_pc;
                    end else begin
                        // request still in flight: keep its address until it completes
                        state_nxt = DROP;
                    end
                end else if (fbus.iresp_data_ok) begin
                    inst_nxt         = fbus.iresp_data;
                    inst_pc_nxt      = req_addr_q;
                    inst_pcplus4_nxt = req_addr_q + 64'd4;
                    inst_valid_nxt   = 1'b1;
                    state_nxt        = HOLD;
                end
            end
            HOLD: begin
                // redirect wins over decode acceptance; bus responses are ignored here
                if (fbus.redirect_valid) begin
                    inst_valid_nxt = 1'b0;
                    pc_nxt         = fbus.redirect_pc;
                    req_addr_nxt   = fbus.redirect_pc;
                    state_nxt      = FETCH;
                end else if (fbus.dec_ready) begin
                    inst_valid_nxt = 1'b0;
                    pc_nxt         = fbus.pred_pc;
                    req_addr_nxt   = fbus.pred_pc;
                    state_nxt      = FETCH;
                end
            end
            DROP: begin
                // latest redirect target wins; the stale response never reaches the buffer
                if (fbus.redirect_valid) begin
                    pc_nxt = fbus.redirect_pc;
                end
                if (fbus.iresp_data_ok) begin
                    req_addr_nxt = fbus.redirect_valid ? fbus.redirect_pc : pc_q;
                    state_nxt    = FETCH;
                end
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, hand-written corner sequences, random run vs model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: dec_ready and iresp_data_ok driven directly by the bench.
module tb_fetch_ctrl;

    localparam logic [63:0] PCINIT = 64'h0000_0000_8000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.PCINIT(PCINIT)) dut (
        .clk   (clk),
        .reset (reset),
        .fbus  (bus.master)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: a request is outstanding whenever the buffer is empty;
    // a redirect seen while a request is outstanding becomes a pending target
    // that replaces the address once the stale response arrives.
    logic        m_buf_vld;
    logic [31:0] m_inst;
    logic [63:0] m_pc, m_p4;
    logic [63:0] m_out;
    logic        m_pend_vld;
    logic [63:0] m_pend;

    task automatic model_update(input logic rst, input logic ok, input logic [31:0] d,
                                input logic rv, input logic [63:0] rpc,
                                input logic dr, input logic [63:0] pr);
        if (rst) begin
            m_buf_vld = 0; m_inst = 0; m_pc = 0; m_p4 = 0;
            m_out = PCINIT; m_pend_vld = 0; m_pend = 0;
        end else if (m_buf_vld) begin
            if (rv) begin
                m_buf_vld = 0; m_out = rpc;
            end else if (dr) begin
                m_buf_vld = 0; m_out = pr;
            end
        end else begin
            if (rv) begin
                m_pend_vld = 1; m_pend = rpc;
            end
            if (ok) begin
                if (m_pend_vld) begin
                    m_out = m_pend; m_pend_vld = 0;
                end else begin
                    m_buf_vld = 1; m_inst = d; m_pc = m_out; m_p4 = m_out + 64'd4;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " ireq_valid"}, 64'(bus.ireq_valid), 64'(!m_buf_vld));
        if (!m_buf_vld) chk({tag, " ireq_addr"}, bus.ireq_addr, m_out);
        chk({tag, " inst_valid"}, 64'(bus.inst_valid), 64'(m_buf_vld));
        chk({tag, " inst"}, 64'(bus.inst), 64'(m_inst));
        chk({tag, " inst_pc"}, bus.inst_pc, m_pc);
        chk({tag, " inst_pcplus4"}, bus.inst_pcplus4, m_p4);
    endtask

    // Apply one cycle of inputs, advance the model, sample just after the edge
    task automatic step(input logic rst, input logic ok, input logic [31:0] d,
                        input logic rv, input logic [63:0] rpc,
                        input logic dr, input logic [63:0] pr, input string tag);
        reset              = rst;
        bus.iresp_data_ok  = ok;
        bus.iresp_data     = d;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.dec_ready      = dr;
        bus.pred_pc        = pr;
        @(posedge clk);
        model_update(rst, ok, d, rv, rpc, dr, pr);
        #1;
        if (tag != "") check_model(tag);
    endtask

    typedef struct {
        logic        rst, ok, rv, dr;
        logic [31:0] d;
        logic [63:0] rpc, pr;
        logic        e_ivld;
        logic [63:0] e_addr;
        logic        e_vld;
        logic [31:0] e_inst;
        logic [63:0] e_pc, e_p4;
    } vec_t;

    function automatic vec_t mk(logic rst, logic ok, logic [31:0] d, logic rv, logic [63:0] rpc,
                                logic dr, logic [63:0] pr, logic e_ivld, logic [63:0] e_addr,
                                logic e_vld, logic [31:0] e_inst, logic [63:0] e_pc, logic [63:0] e_p4);
        vec_t v;
        v.rst = rst; v.ok = ok; v.d = d; v.rv = rv; v.rpc = rpc; v.dr = dr; v.pr = pr;
        v.e_ivld = e_ivld; v.e_addr = e_addr; v.e_vld = e_vld;
        v.e_inst = e_inst; v.e_pc = e_pc; v.e_p4 = e_p4;
        return v;
    endfunction

    localparam int NV = 15;
    vec_t tbl [NV];

    function automatic logic [63:0] rnd_addr();
        case ($urandom_range(0, 3))
            0:       return 64'hFFFF_FFFF_FFFF_FFFC;
            1:       return {32'd0, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        //            rst ok d          rv rpc                   dr pred                  | ivld addr                 vld inst        pc                    pc+4
        tbl[0]  = mk(1, 0, 32'h0,    0, 64'h0,             0, 64'h0,             1, 64'h8000_0000, 0, 32'h0,  64'h0,         64'h0);
        tbl[1]  = mk(0, 0, 32'h0,    0, 64'h0,             0, 64'h0,             1, 64'h8000_0000, 0, 32'h0,  64'h0,         64'h0);
        tbl[2]  = mk(0, 0, 32'h0,    0, 64'h0,             0, 64'h0,             1, 64'h8000_0000, 0, 32'h0,  64'h0,         64'h0);
        tbl[3]  = mk(0, 1, 32'h13,   0, 64'h0,             0, 64'h0,             0, 64'h0,         1, 32'h13, 64'h8000_0000, 64'h8000_0004);
        tbl[4]  = mk(0, 0, 32'h0,    0, 64'h0,             1, 64'h8000_0008,     1, 64'h8000_0008, 0, 32'h13, 64'h8000_0000, 64'h8000_0004);
        tbl[5]  = mk(0, 0, 32'h0,    1, 64'h8000_0100,     0, 64'h0,             1, 64'h8000_0008, 0, 32'h13, 64'h8000_0000, 64'h8000_0004);
        tbl[6]  = mk(0, 0, 32'h0,    0, 64'h0,             0, 64'h0,             1, 64'h8000_0008, 0, 32'h13, 64'h8000_0000, 64'h8000_0004);
        tbl[7]  = mk(0, 1, 32'hDEAD, 0, 64'h0,             0, 64'h0,             1, 64'h8000_0100, 0, 32'h13, 64'h8000_0000, 64'h8000_0004);
        tbl[8]  = mk(0, 1, 32'hBEEF, 1, 64'h8000_0200,     0, 64'h0,             1, 64'h8000_0200, 0, 32'h13, 64'h8000_0000, 64'h8000_0004);
        tbl[9]  = mk(0, 1, 32'h17,   0, 64'h0,             0, 64'h0,             0, 64'h0,         1, 32'h17, 64'h8000_0200, 64'h8000_0204);
        tbl[10] = mk(0, 0, 32'h0,    1, 64'h9000_0000,     0, 64'h0,             1, 64'h9000_0000, 0, 32'h17, 64'h8000_0200, 64'h8000_0204);
        tbl[11] = mk(0, 1, 32'h33,   0, 64'h0,             0, 64'h0,             0, 64'h0,         1, 32'h33, 64'h9000_0000, 64'h9000_0004);
        tbl[12] = mk(0, 1, 32'h55,   0, 64'h0,             0, 64'h0,             0, 64'h0,         1, 32'h33, 64'h9000_0000, 64'h9000_0004);
        tbl[13] = mk(0, 0, 32'h0,    0, 64'h0,             1, 64'h9000_0002,     1, 64'h9000_0002, 0, 32'h33, 64'h9000_0000, 64'h9000_0004);
        tbl[14] = mk(0, 1, 32'h44,   0, 64'h0,             0, 64'h0,             0, 64'h0,         1, 32'h44, 64'h9000_0002, 64'h9000_0006);

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            step(tbl[i].rst, tbl[i].ok, tbl[i].d, tbl[i].rv, tbl[i].rpc, tbl[i].dr, tbl[i].pr, "");
            chk($sformatf("vec%0d ireq_valid", i), 64'(bus.ireq_valid), 64'(tbl[i].e_ivld));
            if (tbl[i].e_ivld) chk($sformatf("vec%0d ireq_addr", i), bus.ireq_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d inst_valid", i), 64'(bus.inst_valid), 64'(tbl[i].e_vld));
            chk($sformatf("vec%0d inst", i), 64'(bus.inst), 64'(tbl[i].e_inst));
            chk($sformatf("vec%0d inst_pc", i), bus.inst_pc, tbl[i].e_pc);
            chk($sformatf("vec%0d inst_pcplus4", i), bus.inst_pcplus4, tbl[i].e_p4);
        end

        // Decode stall: buffer frozen for 5 cycles despite bus noise, then handshake
        step(1, 0, 0, 0, 0, 0, 0, "stall rst");
        step(0, 1, 32'h1, 0, 0, 0, 0, "stall fill");
        for (int i = 0; i < 5; i++) begin
            step(0, 1'($urandom_range(0, 1)), $urandom, 0, 0, 0, rnd_addr(), "stall hold");
            chk("stall inst_pc", bus.inst_pc, 64'h8000_0000);
            chk("stall inst", 64'(bus.inst), 64'h1);
            chk("stall inst_valid", 64'(bus.inst_valid), 64'd1);
        end
        step(0, 0, 0, 0, 0, 1, 64'h8000_0040, "stall accept");
        chk("accept ireq_valid", 64'(bus.ireq_valid), 64'd1);
        chk("accept ireq_addr", bus.ireq_addr, 64'h8000_0040);

        // Two redirects while a request is in flight: latest one wins after drain
        step(0, 0, 0, 1, 64'h100, 0, 0, "drop r1");
        chk("drop r1 addr", bus.ireq_addr, 64'h8000_0040);
        step(0, 0, 0, 1, 64'h200, 0, 0, "drop r2");
        chk("drop r2 addr", bus.ireq_addr, 64'h8000_0040);
        step(0, 0, 0, 0, 0, 0, 0, "drop wait");
        step(0, 1, 32'hBAD, 0, 0, 0, 0, "drop drain");
        chk("drain ireq_addr", bus.ireq_addr, 64'h200);
        chk("drain inst_valid", 64'(bus.inst_valid), 64'd0);

        // PC wrap at the top of the address space, then reset during DROP
        step(0, 1, 32'h7, 0, 0, 0, 0, "wrap fill0");
        step(0, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, "wrap pred");
        step(0, 1, 32'h9, 0, 0, 0, 0, "wrap fill1");
        chk("wrap inst_pc", bus.inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap inst_pcplus4", bus.inst_pcplus4, 64'h0);
        step(0, 0, 0, 0, 0, 1, 64'h1000, "wrap next");
        step(0, 0, 0, 1, 64'h2000, 0, 0, "rstdrop redirect");
        step(1, 0, 0, 1, 64'h3000, 1, 64'h4000, "rstdrop reset");
        chk("rstdrop ireq_valid", 64'(bus.ireq_valid), 64'd1);
        chk("rstdrop ireq_addr", bus.ireq_addr, PCINIT);
        chk("rstdrop inst_valid", 64'(bus.inst_valid), 64'd0);
        chk("rstdrop inst_pc", bus.inst_pc, 64'h0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 63) == 0),
                 1'($urandom_range(0, 2) == 0), $urandom,
                 1'($urandom_range(0, 7) == 0), rnd_addr(),
                 1'($urandom_range(0, 1)), rnd_addr(), "rand");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
